// File: rtl/bank_seq_pkg.sv
// Shared definitions for the bank write sequencer.
//   seq_state_e : sequencer FSM encoding (idle / write / recover)
//   WE_CNT_W    : width of the enable hold counter
package bank_seq_pkg;

   localparam int unsigned WE_CNT_W = 4;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StWrite   = 2'd1,
      StRecover = 2'd2
   } seq_state_e;

endpackage

// File: rtl/bank_onehot_decoder.sv
// One-hot bank decoder.
//   idx_i    : bank index
//   en_i     : decode enable
//   onehot_o : one-hot of idx_i; all zero when en_i is low or idx_i >= NUM_BANKS
module bank_onehot_decoder #(
   parameter int unsigned NUM_BANKS = 4,
   parameter int unsigned SEL_W     = 2
) (
   input  logic [SEL_W-1:0]     idx_i,
   input  logic                 en_i,
   output logic [NUM_BANKS-1:0] onehot_o
);

   // Only indices below NUM_BANKS can match, so out-of-range indices decode to zero.
   always_comb begin
      onehot_o = '0;
      for (int unsigned i = 0; i < NUM_BANKS; i++) begin
         if (en_i && (idx_i == SEL_W'(i))) begin
            onehot_o[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bank_write_sequencer.sv
// Bank write sequencer: accepts one write request at a time, drives a one-hot bank write
// enable for WE_CYCLES cycles, then inserts one recovery cycle. Requests to locked or
// non-existent banks are consumed and answered with a single-cycle wr_err pulse.
//   wb_clk_i / wb_rst_i        : clock, synchronous active-high reset
//   req_valid / req_ready      : request handshake
//   req_bank/req_addr/req_data : request payload
//   bank_lock                  : per-bank lock, sampled at acceptance
//   bank_we/bank_addr/bank_data: registered bank write interface
//   wr_done / wr_err           : completion and reject pulses
module bank_write_sequencer
   import bank_seq_pkg::*;
#(
   parameter int unsigned NUM_BANKS = 4,
   parameter int unsigned SEL_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned WE_CYCLES = 1
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [SEL_W-1:0]     req_bank,
   input  logic [ADDR_W-1:0]    req_addr,
   input  logic [DATA_W-1:0]    req_data,
   input  logic [NUM_BANKS-1:0] bank_lock,
   output logic [NUM_BANKS-1:0] bank_we,
   output logic [ADDR_W-1:0]    bank_addr,
   output logic [DATA_W-1:0]    bank_data,
   output logic                 wr_done,
   output logic                 wr_err
);

   seq_state_e          state_q, state_d;
   logic [WE_CNT_W-1:0] cnt_q, cnt_d;
   logic [SEL_W-1:0]    bank_q, bank_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [NUM_BANKS-1:0] we_q, we_d;
   logic                ready_q, ready_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic                 accept;
   logic                 req_ok;
   logic [SEL_W-1:0]     dec_idx;
   logic                 dec_en;
   logic [NUM_BANKS-1:0] dec_onehot;

   // The single decoder serves two purposes: in idle it range-checks and decodes the
   // incoming bank, during a write it regenerates the enable from the latched bank.
   bank_onehot_decoder #(
      .NUM_BANKS (NUM_BANKS),
      .SEL_W     (SEL_W)
   ) u_decoder (
      .idx_i    (dec_idx),
      .en_i     (dec_en),
      .onehot_o (dec_onehot)
   );

   always_comb begin
      accept  = req_valid && ready_q;
      dec_idx = (state_q == StIdle) ? req_bank : bank_q;
      dec_en  = accept || (state_q == StWrite);
      // Zero decode covers out-of-range banks; masking with the lock covers locked ones.
      req_ok  = |(dec_onehot & ~bank_lock);

      state_d = state_q;
      cnt_d   = cnt_q;
      bank_d  = bank_q;
      addr_d  = addr_q;
      data_d  = data_q;
      err_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (req_ok) begin
                  bank_d  = req_bank;
                  addr_d  = req_addr;
                  data_d  = req_data;
                  cnt_d   = WE_CNT_W'(WE_CYCLES - 1);
                  state_d = StWrite;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StWrite: begin
            if (cnt_q == '0) begin
               state_d = StRecover;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StRecover: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Outputs are registered, so they are derived from the next state.
      we_d    = (state_d == StWrite) ? dec_onehot : '0;
      done_d  = (state_d == StWrite) && (cnt_d == '0);
      ready_d = (state_d == StIdle);
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         bank_q  <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         we_q    <= '0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bank_q  <= bank_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         we_q    <= we_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign req_ready = ready_q;
   assign bank_we   = we_q;
   assign bank_addr = addr_q;
   assign bank_data = data_q;
   assign wr_done   = done_q;
   assign wr_err    = err_q;

endmodule

// File: tb/tb_bank_write_sequencer.sv
// Directed bench for bank_write_sequencer using three instances:
//   dut_a: 4 banks, WE_CYCLES=1; dut_b: 4 banks, WE_CYCLES=3; dut_c: 3 banks, WE_CYCLES=4.
module tb_bank_write_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        va = 1'b0, vb = 1'b0, vc = 1'b0;
   logic [1:0]  req_bank = '0;
   logic [7:0]  req_addr = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  bank_lock = '0;

   logic        ready_a, done_a, err_a;
   logic [3:0]  we_a;
   logic [7:0]  addr_a;
   logic [31:0] data_a;
   logic        ready_b, done_b, err_b;
   logic [3:0]  we_b;
   logic [7:0]  addr_b;
   logic [31:0] data_b;
   logic        ready_c, done_c, err_c;
   logic [2:0]  we_c;
   logic [7:0]  addr_c;
   logic [31:0] data_c;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bank_write_sequencer #(.NUM_BANKS(4), .SEL_W(2), .ADDR_W(8), .DATA_W(32), .WE_CYCLES(1))
   dut_a (
      .wb_clk_i (clk), .wb_rst_i (rst), .req_valid (va), .req_ready (ready_a),
      .req_bank (req_bank), .req_addr (req_addr), .req_data (req_data),
      .bank_lock (bank_lock), .bank_we (we_a), .bank_addr (addr_a), .bank_data (data_a),
      .wr_done (done_a), .wr_err (err_a)
   );

   bank_write_sequencer #(.NUM_BANKS(4), .SEL_W(2), .ADDR_W(8), .DATA_W(32), .WE_CYCLES(3))
   dut_b (
      .wb_clk_i (clk), .wb_rst_i (rst), .req_valid (vb), .req_ready (ready_b),
      .req_bank (req_bank), .req_addr (req_addr), .req_data (req_data),
      .bank_lock (bank_lock), .bank_we (we_b), .bank_addr (addr_b), .bank_data (data_b),
      .wr_done (done_b), .wr_err (err_b)
   );

   bank_write_sequencer #(.NUM_BANKS(3), .SEL_W(2), .ADDR_W(8), .DATA_W(32), .WE_CYCLES(4))
   dut_c (
      .wb_clk_i (clk), .wb_rst_i (rst), .req_valid (vc), .req_ready (ready_c),
      .req_bank (req_bank), .req_addr (req_addr), .req_data (req_data),
      .bank_lock (bank_lock[2:0]), .bank_we (we_c), .bank_addr (addr_c), .bank_data (data_c),
      .wr_done (done_c), .wr_err (err_c)
   );

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL rst_ready_a got=%b want=1", ready_a); end
      total++; if (we_a !== 4'b0) begin bad++; $display("FAIL rst_we_a got=%b want=0000", we_a); end
      total++; if (addr_a !== 8'h0) begin bad++; $display("FAIL rst_addr_a got=%h want=00", addr_a); end
      total++; if (data_a !== 32'h0) begin bad++; $display("FAIL rst_data_a got=%h want=0", data_a); end
      total++; if (done_a !== 1'b0 || err_a !== 1'b0) begin
         bad++; $display("FAIL rst_pulses_a got done=%b err=%b want 0 0", done_a, err_a);
      end
      total++; if (ready_b !== 1'b1 || we_b !== 4'b0) begin
         bad++; $display("FAIL rst_b got ready=%b we=%b want 1 0000", ready_b, we_b);
      end
      total++; if (ready_c !== 1'b1 || we_c !== 3'b0) begin
         bad++; $display("FAIL rst_c got ready=%b we=%b want 1 000", ready_c, we_c);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      req_bank = 2'd2; req_addr = 8'h10; req_data = 32'hDEADBEEF; bank_lock = 4'b0;
      va = 1'b1;
      total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL single_pre_ready got=%b want=1", ready_a); end
      tick();
      va = 1'b0;
      total++; if (we_a !== 4'b0100) begin bad++; $display("FAIL single_we got=%b want=0100", we_a); end
      total++; if (addr_a !== 8'h10) begin bad++; $display("FAIL single_addr got=%h want=10", addr_a); end
      total++; if (data_a !== 32'hDEADBEEF) begin
         bad++; $display("FAIL single_data got=%h want=deadbeef", data_a);
      end
      total++; if (done_a !== 1'b1) begin bad++; $display("FAIL single_done got=%b want=1", done_a); end
      total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL single_ready1 got=%b want=0", ready_a); end
      tick();
      total++; if (we_a !== 4'b0 || done_a !== 1'b0 || ready_a !== 1'b0) begin
         bad++; $display("FAIL single_recover got we=%b done=%b ready=%b want 0000 0 0",
                         we_a, done_a, ready_a);
      end
      total++; if (addr_a !== 8'h10) begin bad++; $display("FAIL single_addr_hold got=%h want=10", addr_a); end
      tick();
      total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL single_ready_back got=%b want=1", ready_a); end
   endtask

   task automatic test_back_to_back();
      logic [1:0] banks [3];
      logic [3:0] exp_we;
      banks[0] = 2'd0; banks[1] = 2'd1; banks[2] = 2'd3;
      bank_lock = 4'b0;
      vb = 1'b1;
      for (int c = 0; c < 15; c++) begin
         req_bank = banks[c / 5];
         req_addr = 8'(c);
         total++; if (ready_b !== ((c % 5) == 0)) begin
            bad++; $display("FAIL b2b_ready c=%0d got=%b want=%b", c, ready_b, (c % 5) == 0);
         end
         tick();
         exp_we = ((c % 5) < 3) ? (4'b0001 << banks[c / 5]) : 4'b0000;
         total++; if (we_b !== exp_we) begin
            bad++; $display("FAIL b2b_we c=%0d got=%b want=%b", c, we_b, exp_we);
         end
         total++; if (done_b !== ((c % 5) == 2)) begin
            bad++; $display("FAIL b2b_done c=%0d got=%b want=%b", c, done_b, (c % 5) == 2);
         end
      end
      vb = 1'b0;
      // Address latched at the third accept (cycle 10) must still be held.
      total++; if (addr_b !== 8'd10) begin bad++; $display("FAIL b2b_addr got=%0d want=10", addr_b); end
      tick();
   endtask

   task automatic test_locked();
      bank_lock = 4'b0010;
      req_bank = 2'd1;
      va = 1'b1;
      tick();
      total++; if (err_a !== 1'b1) begin bad++; $display("FAIL lock_err got=%b want=1", err_a); end
      total++; if (we_a !== 4'b0) begin bad++; $display("FAIL lock_we got=%b want=0000", we_a); end
      total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL lock_ready got=%b want=1", ready_a); end
      req_bank = 2'd0;
      tick();
      va = 1'b0;
      total++; if (err_a !== 1'b0) begin bad++; $display("FAIL lock_err_clear got=%b want=0", err_a); end
      total++; if (we_a !== 4'b0001 || done_a !== 1'b1) begin
         bad++; $display("FAIL lock_follow got we=%b done=%b want 0001 1", we_a, done_a);
      end
      tick();
      tick();
      bank_lock = 4'b0;
   endtask

   task automatic test_out_of_range();
      req_bank = 2'd3;
      vc = 1'b1;
      tick();
      vc = 1'b0;
      total++; if (err_c !== 1'b1) begin bad++; $display("FAIL oor_err got=%b want=1", err_c); end
      total++; if (we_c !== 3'b0 || ready_c !== 1'b1) begin
         bad++; $display("FAIL oor_state got we=%b ready=%b want 000 1", we_c, ready_c);
      end
      tick();
      total++; if (err_c !== 1'b0 || we_c !== 3'b0) begin
         bad++; $display("FAIL oor_after got err=%b we=%b want 0 000", err_c, we_c);
      end
   endtask

   task automatic test_reset_mid_write();
      logic saw_done;
      req_bank = 2'd1;
      bank_lock = 4'b0;
      vc = 1'b1;
      tick();
      vc = 1'b0;
      total++; if (we_c !== 3'b010) begin bad++; $display("FAIL mid_we1 got=%b want=010", we_c); end
      tick();
      total++; if (we_c !== 3'b010 || done_c !== 1'b0) begin
         bad++; $display("FAIL mid_we2 got we=%b done=%b want 010 0", we_c, done_c);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++; if (we_c !== 3'b0 || ready_c !== 1'b1) begin
         bad++; $display("FAIL mid_rst got we=%b ready=%b want 000 1", we_c, ready_c);
      end
      total++; if (done_c !== 1'b0 || err_c !== 1'b0) begin
         bad++; $display("FAIL mid_rst_pulse got done=%b err=%b want 0 0", done_c, err_c);
      end
      saw_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done_c !== 1'b0 || we_c !== 3'b0) saw_done = 1'b1;
      end
      total++; if (saw_done !== 1'b0) begin
         bad++; $display("FAIL mid_truncated got activity=%b want=0", saw_done);
      end
   endtask

   task automatic test_random();
      int busy = 0;
      int exp_ok = 0, exp_rej = 0, got_done = 0, got_err = 0;
      int bad_hot = 0, bad_rdy = 0;
      logic acc, ok;
      for (int i = 0; i < 300; i++) begin
         vb        = 1'($urandom_range(0, 1));
         req_bank  = 2'($urandom_range(0, 3));
         bank_lock = 4'($urandom_range(0, 15));
         if (ready_b !== (busy == 0)) bad_rdy++;
         acc = vb && (busy == 0);
         ok  = !bank_lock[req_bank];
         tick();
         if (done_b === 1'b1) got_done++;
         if (err_b === 1'b1) got_err++;
         if ($countones(we_b) > 1) bad_hot++;
         if (acc && ok) begin
            exp_ok++;
            busy = 4;
         end else begin
            if (acc) exp_rej++;
            if (busy > 0) busy--;
         end
      end
      vb = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done_b === 1'b1) got_done++;
         if (err_b === 1'b1) got_err++;
         if ($countones(we_b) > 1) bad_hot++;
      end
      total++; if (bad_hot != 0) begin bad++; $display("FAIL rnd_onehot got=%0d want=0", bad_hot); end
      total++; if (bad_rdy != 0) begin bad++; $display("FAIL rnd_ready got=%0d want=0", bad_rdy); end
      total++; if (got_done != exp_ok) begin
         bad++; $display("FAIL rnd_done_count got=%0d want=%0d", got_done, exp_ok);
      end
      total++; if (got_err != exp_rej) begin
         bad++; $display("FAIL rnd_err_count got=%0d want=%0d", got_err, exp_rej);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_locked();
      test_out_of_range();
      test_reset_mid_write();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
